// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the single-clock FIFO.
// Widths that depend on the depth are derived inside each module from its own parameters.
package sync_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Address width for a given depth; depths below 2 still get one address bit.
    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for sync_fifo: one write port and one registered read port.
// The read register resets to zero, so the popped-data output is never X after reset.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int G_WIDTH = DEFAULT_WIDTH,
    parameter int G_DEPTH = DEFAULT_DEPTH,
    localparam int AW = addr_width(G_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [G_WIDTH-1:0] wdata,
    input  logic               re,
    input  logic [AW-1:0]      raddr,
    output logic [G_WIDTH-1:0] rdata
);

    logic [G_WIDTH-1:0] mem [G_DEPTH];

    // Storage is deliberately left unreset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty status, registered overflow/underflow pulses
// and a read-done strobe qualifying o_data. Rejected accesses leave the state untouched.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int G_WIDTH = DEFAULT_WIDTH,
    parameter int G_DEPTH = DEFAULT_DEPTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_wr,
    input  logic               i_rd,
    input  logic [G_WIDTH-1:0] i_data,
    output logic [G_WIDTH-1:0] o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_overflow,
    output logic               o_underflow,
    output logic               f_rd_done
);

    localparam int AW = addr_width(G_DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_ok;
    logic          rd_ok;

    // Status comes only from the registered occupancy, so same-cycle traffic cannot change it.
    assign o_full  = (count == CW'(G_DEPTH));
    assign o_empty = (count == '0);

    assign wr_ok = i_wr && !o_full;
    assign rd_ok = i_rd && !o_empty;

    sync_fifo_mem #(
        .G_WIDTH (G_WIDTH),
        .G_DEPTH (G_DEPTH)
    ) u_mem (
        .clk   (i_clk),
        .rst   (i_rst),
        .we    (wr_ok && !i_rst),
        .waddr (wr_ptr),
        .wdata (i_data),
        .re    (rd_ok),
        .raddr (rd_ptr),
        .rdata (o_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            f_rd_done   <= 1'b0;
        end else begin
            o_overflow  <= i_wr && o_full;
            o_underflow <= i_rd && o_empty;
            f_rd_done   <= rd_ok;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Pointers wrap naturally because the depth is a power of two.
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (8-bit, depth 4).
// Each step drives inputs, waits one rising edge, then checks outputs 1 ns later.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic       rd_done;

    int checks = 0;
    int errors = 0;

    sync_fifo #(
        .G_WIDTH (8),
        .G_DEPTH (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_wr        (wr),
        .i_rd        (rd),
        .i_data      (din),
        .o_data      (dout),
        .o_full      (full),
        .o_empty     (empty),
        .o_overflow  (ovf),
        .o_underflow (unf),
        .f_rd_done   (rd_done)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic w, input logic rr, input logic [7:0] d);
        rst = r;
        wr  = w;
        rd  = rr;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Checks status flags and pulses as a group.
    task automatic checkFlags(input string tag, input logic e_full, input logic e_empty,
                              input logic e_ovf, input logic e_unf, input logic e_done);
        checkOutput({tag, "_full"},  32'(full),    32'(e_full));
        checkOutput({tag, "_empty"}, 32'(empty),   32'(e_empty));
        checkOutput({tag, "_ovf"},   32'(ovf),     32'(e_ovf));
        checkOutput({tag, "_unf"},   32'(unf),     32'(e_unf));
        checkOutput({tag, "_done"},  32'(rd_done), 32'(e_done));
    endtask

    logic [7:0] fill_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] pair_exp  [6] = '{8'h01, 8'h02, 8'hA0, 8'hA1, 8'hA2, 8'hA3};

    initial begin
        rst = 1'b1; wr = 1'b0; rd = 1'b0; din = 8'h00;

        // Reset, then idle with request lines held low
        applyStimulus(1, 0, 0, 8'h00);
        applyStimulus(1, 1, 1, 8'hFF);
        checkFlags("rst", 0, 1, 0, 0, 0);
        checkOutput("rst_data", 32'(dout), 32'h00);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00);
        checkFlags("idle", 0, 1, 0, 0, 0);
        checkOutput("idle_data", 32'(dout), 32'h00);

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, fill_data[i]);
            checkOutput($sformatf("fill%0d_empty", i), 32'(empty), 32'h0);
            checkOutput($sformatf("fill%0d_full", i), 32'(full), (i == 3) ? 32'h1 : 32'h0);
        end

        // Overflow write is dropped and pulses once
        applyStimulus(0, 1, 0, 8'h55);
        checkFlags("ovf", 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 8'h00);
        checkFlags("ovf_after", 1, 0, 0, 0, 0);

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 8'h00);
            checkOutput($sformatf("rd%0d_data", i), 32'(dout), 32'(fill_data[i]));
            checkOutput($sformatf("rd%0d_done", i), 32'(rd_done), 32'h1);
        end
        checkOutput("drain_empty", 32'(empty), 32'h1);
        applyStimulus(0, 0, 0, 8'h00);
        checkFlags("drain_idle", 0, 1, 0, 0, 0);
        checkOutput("drain_hold", 32'(dout), 32'h44);

        // Underflow read is dropped, o_data holds
        applyStimulus(0, 0, 1, 8'h00);
        checkFlags("unf", 0, 1, 0, 1, 0);
        checkOutput("unf_hold", 32'(dout), 32'h44);
        applyStimulus(0, 0, 0, 8'h00);
        checkOutput("unf_after", 32'(unf), 32'h0);

        // Simultaneous access with two entries stored; pointers wrap
        applyStimulus(0, 1, 0, 8'h01);
        applyStimulus(0, 1, 0, 8'h02);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 1, 8'hA0 + 8'(i));
            checkOutput($sformatf("pair%0d_data", i), 32'(dout), 32'(pair_exp[i]));
            checkFlags($sformatf("pair%0d", i), 0, 0, 0, 0, 1);
        end
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("pair_tail0", 32'(dout), 32'hA4);
        checkOutput("pair_tail0_empty", 32'(empty), 32'h0);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("pair_tail1", 32'(dout), 32'hA5);
        checkOutput("pair_tail1_empty", 32'(empty), 32'h1);

        // Simultaneous access when empty: write accepted, read underflows
        applyStimulus(0, 1, 1, 8'hC1);
        checkFlags("empty_rw", 0, 0, 0, 1, 0);
        checkOutput("empty_rw_hold", 32'(dout), 32'hA5);
        applyStimulus(0, 0, 1, 8'h00);
        checkOutput("empty_rw_pop", 32'(dout), 32'hC1);
        checkFlags("empty_rw_pop", 0, 1, 0, 0, 1);

        // Simultaneous access when full: read accepted, write overflows
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 8'hD0 + 8'(i));
        applyStimulus(0, 1, 1, 8'hEE);
        checkFlags("full_rw", 0, 0, 1, 0, 1);
        checkOutput("full_rw_data", 32'(dout), 32'hD0);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(0, 0, 1, 8'h00);
            checkOutput($sformatf("full_rw_rd%0d", i), 32'(dout), 32'(8'hD0 + 8'(i)));
        end
        checkOutput("full_rw_empty", 32'(empty), 32'h1);

        // Reset mid-operation discards contents
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 8'hB1 + 8'(i));
        applyStimulus(1, 0, 0, 8'h00);
        checkFlags("midrst", 0, 1, 0, 0, 0);
        checkOutput("midrst_data", 32'(dout), 32'h00);
        applyStimulus(0, 0, 1, 8'h00);
        checkFlags("midrst_rd", 0, 1, 0, 1, 0);
        checkOutput("midrst_rd_data", 32'(dout), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
